// File: rtl/shiftreg_sequencer_pkg.sv
// Shared definitions for the shift-register sequencer and the generator it feeds.
// Keeps the segment lengths in one place so both ends agree on frame geometry.
package shiftreg_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DYN  = 2'd1,
        ST_STAT = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    localparam int SIZESRDYN_DEF  = 16;
    localparam int SIZESRSTAT_DEF = 88;
    localparam int FRAME_LEN      = SIZESRDYN_DEF + SIZESRSTAT_DEF;
    localparam int FRAMECNT_W     = 16;

endpackage

// File: rtl/shiftreg_sequencer_if.sv
// Control/status bundle between a frame requester (master) and the sequencer (slave).
// Inputs are sampled on the sequencer clock; every status output is a flop.
interface shiftreg_sequencer_if #(
    parameter int CNTW = 7,
    parameter int GAPW = 8
) ();

    logic                                        START;
    logic                                        CONT;
    logic [GAPW-1:0]                             GAP;
    logic                                        ABORT;
    logic                                        SELDYN;
    logic                                        SELSTAT;
    logic                                        BUSY;
    logic                                        DONE;
    logic [CNTW-1:0]                             BITCNT;
    logic [shiftreg_sequencer_pkg::FRAMECNT_W-1:0] FRAMECNT;

    modport master (
        output START, CONT, GAP, ABORT,
        input  SELDYN, SELSTAT, BUSY, DONE, BITCNT, FRAMECNT
    );

    modport slave (
        input  START, CONT, GAP, ABORT,
        output SELDYN, SELSTAT, BUSY, DONE, BITCNT, FRAMECNT
    );

endinterface

// File: rtl/shiftreg_sequencer.sv
// Generates SELDYN then SELSTAT strobes of exact length, single-shot or continuous with an idle gap.
// Latency: outputs change on the edge that samples START/ABORT; no backpressure, ABORT preempts everything.
module shiftreg_sequencer
    import shiftreg_sequencer_pkg::*;
#(
    parameter int SIZESRDYN  = SIZESRDYN_DEF,
    parameter int SIZESRSTAT = SIZESRSTAT_DEF,
    parameter int CNTW       = 7,
    parameter int GAPW       = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    shiftreg_sequencer_if.slave  bus
);

    localparam logic [CNTW-1:0] DYN_LAST  = CNTW'(SIZESRDYN - 1);
    localparam logic [CNTW-1:0] STAT_LAST = CNTW'(SIZESRSTAT - 1);

    state_t                  state_q,    state_d;
    logic [CNTW-1:0]         bitcnt_q,   bitcnt_d;
    logic [GAPW-1:0]         gap_q,      gap_d;
    logic [FRAMECNT_W-1:0]   framecnt_q, framecnt_d;
    logic                    done_q,     done_d;
    logic                    seldyn_q,   seldyn_d;
    logic                    selstat_q,  selstat_d;
    logic                    busy_q,     busy_d;

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        gap_d      = gap_q;
        framecnt_d = framecnt_q;
        done_d     = 1'b0;

        if (bus.ABORT) begin
            state_d  = ST_IDLE;
            bitcnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.START) begin
                        state_d  = ST_DYN;
                        bitcnt_d = '0;
                    end
                end
                ST_DYN: begin
                    if (bitcnt_q == DYN_LAST) begin
                        state_d  = ST_STAT;
                        bitcnt_d = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + CNTW'(1);
                    end
                end
                ST_STAT: begin
                    if (bitcnt_q == STAT_LAST) begin
                        done_d     = 1'b1;
                        framecnt_d = framecnt_q + FRAMECNT_W'(1);
                        gap_d      = bus.GAP;
                        bitcnt_d   = '0;
                        // A zero gap chains straight into the next dynamic segment.
                        if (!bus.CONT) begin
                            state_d = ST_IDLE;
                        end else if (bus.GAP == '0) begin
                            state_d = ST_DYN;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + CNTW'(1);
                    end
                end
                ST_GAP: begin
                    // gap_q holds the remaining idle cycles; it is never zero here.
                    if (!bus.CONT) begin
                        state_d = ST_IDLE;
                    end else if (gap_q == GAPW'(1)) begin
                        state_d = ST_DYN;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q - GAPW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        seldyn_d  = (state_d == ST_DYN);
        selstat_d = (state_d == ST_STAT);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            gap_q      <= '0;
            framecnt_q <= '0;
            done_q     <= 1'b0;
            seldyn_q   <= 1'b0;
            selstat_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            gap_q      <= gap_d;
            framecnt_q <= framecnt_d;
            done_q     <= done_d;
            seldyn_q   <= seldyn_d;
            selstat_q  <= selstat_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.SELDYN   = seldyn_q;
    assign bus.SELSTAT  = selstat_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.BITCNT   = bitcnt_q;
    assign bus.FRAMECNT = framecnt_q;

endmodule

// File: tb/tb_shiftreg_sequencer.sv
// Bench for shiftreg_sequencer: directed frame scenarios plus random control traffic
// scored against a frame-position reference model.
module tb_shiftreg_sequencer;
    import shiftreg_sequencer_pkg::*;

    localparam int NDYN  = SIZESRDYN_DEF;
    localparam int NSTAT = SIZESRSTAT_DEF;
    localparam int CNTW  = 7;
    localparam int GAPW  = 8;
    localparam int OW    = 4 + CNTW + FRAMECNT_W;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    shiftreg_sequencer_if #(.CNTW(CNTW), .GAPW(GAPW)) bus ();

    shiftreg_sequencer #(
        .SIZESRDYN (NDYN),
        .SIZESRSTAT(NSTAT),
        .CNTW      (CNTW),
        .GAPW      (GAPW)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Reference model: position inside the 104-cycle frame, plus idle cycles left in a gap.
    bit              m_active;
    int              m_pos;
    int              m_gap_left;
    logic [15:0]     m_frames;
    bit              m_done;

    function automatic void model_reset();
        m_active   = 1'b0;
        m_pos      = 0;
        m_gap_left = 0;
        m_frames   = 16'h0000;
        m_done     = 1'b0;
    endfunction

    function automatic void model_edge();
        m_done = 1'b0;
        if (bus.ABORT) begin
            m_active   = 1'b0;
            m_gap_left = 0;
        end else if (m_active) begin
            if (m_pos == FRAME_LEN - 1) begin
                m_done   = 1'b1;
                m_frames = m_frames + 16'd1;
                m_active = 1'b0;
                if (bus.CONT) begin
                    if (bus.GAP == 0) begin
                        m_active = 1'b1;
                        m_pos    = 0;
                    end else begin
                        m_gap_left = int'(bus.GAP);
                    end
                end
            end else begin
                m_pos = m_pos + 1;
            end
        end else if (m_gap_left > 0) begin
            if (!bus.CONT) begin
                m_gap_left = 0;
            end else if (m_gap_left == 1) begin
                m_gap_left = 0;
                m_active   = 1'b1;
                m_pos      = 0;
            end else begin
                m_gap_left = m_gap_left - 1;
            end
        end else if (bus.START) begin
            m_active = 1'b1;
            m_pos    = 0;
        end
    endfunction

    function automatic logic [OW-1:0] model_out();
        logic            sd, ss, bz;
        logic [CNTW-1:0] bc;
        sd = m_active && (m_pos < NDYN);
        ss = m_active && (m_pos >= NDYN);
        bz = m_active || (m_gap_left > 0);
        if (!m_active)          bc = '0;
        else if (m_pos < NDYN)  bc = CNTW'(m_pos);
        else                    bc = CNTW'(m_pos - NDYN);
        return {sd, ss, bz, m_done, bc, m_frames};
    endfunction

    task automatic step();
        @(posedge CLK);
        if (RST_N) model_edge();
        #1;
    endtask

    // Scoreboard and strobe exclusivity, sampled every falling edge.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                checks++;
                if (bus.SELDYN === 1'b1 && bus.SELSTAT === 1'b1) begin
                    errors++;
                    $display("FAIL mutex t=%0t SELDYN=%b SELSTAT=%b required not both 1", $time, bus.SELDYN, bus.SELSTAT);
                end
                checks++;
                if ({bus.SELDYN, bus.SELSTAT, bus.BUSY, bus.DONE, bus.BITCNT, bus.FRAMECNT} !== model_out()) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got {dyn,stat,busy,done,bitcnt,frames}=%h required %h",
                             $time, {bus.SELDYN, bus.SELSTAT, bus.BUSY, bus.DONE, bus.BITCNT, bus.FRAMECNT}, model_out());
                end
            end
        end
    end

    task automatic test_reset();
        bus.START = 1'b0; bus.CONT = 1'b0; bus.GAP = '0; bus.ABORT = 1'b0;
        RST_N = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #12;
        checks++;
        if ({bus.SELDYN, bus.SELSTAT, bus.BUSY, bus.DONE, bus.BITCNT, bus.FRAMECNT} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h required 0", {bus.SELDYN, bus.SELSTAT, bus.BUSY, bus.DONE, bus.BITCNT, bus.FRAMECNT});
        end
        #1 RST_N = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [15:0] base;
        base = m_frames;
        bus.CONT = 1'b0; bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            logic [3:0] exp_v;
            exp_v = {(c <= NDYN), (c > NDYN && c <= FRAME_LEN), (c == FRAME_LEN + 1), (c <= FRAME_LEN)};
            checks++;
            if ({bus.SELDYN, bus.SELSTAT, bus.DONE, bus.BUSY} !== exp_v) begin
                errors++;
                $display("FAIL single_frame cycle %0d got {dyn,stat,done,busy}=%b required %b",
                         c, {bus.SELDYN, bus.SELSTAT, bus.DONE, bus.BUSY}, exp_v);
            end
            step();
        end
        checks++;
        if (bus.FRAMECNT !== base + 16'd1) begin
            errors++;
            $display("FAIL single_framecnt got %h required %h", bus.FRAMECNT, base + 16'd1);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        int          dq[$];
        int          idle_cycles;
        base = m_frames;
        idle_cycles = 0;
        bus.CONT = 1'b1; bus.GAP = '0; bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int c = 1; c <= 313; c++) begin
            if (bus.DONE) dq.push_back(c);
            if (!bus.BUSY) idle_cycles++;
            if (c == 104) begin
                checks++;
                if ({bus.SELDYN, bus.SELSTAT} !== 2'b01) begin
                    errors++;
                    $display("FAIL b2b_last_stat got {dyn,stat}=%b required 01", {bus.SELDYN, bus.SELSTAT});
                end
            end
            if (c == 105) begin
                checks++;
                if ({bus.SELDYN, bus.SELSTAT, bus.DONE, bus.BITCNT} !== {3'b101, 7'd0}) begin
                    errors++;
                    $display("FAIL b2b_first_dyn got {dyn,stat,done,bitcnt}=%b required 1010000000",
                             {bus.SELDYN, bus.SELSTAT, bus.DONE, bus.BITCNT});
                end
            end
            step();
        end
        checks++;
        if (dq.size() != 3 || dq[0] != 105 || dq[1] != 209 || dq[2] != 313) begin
            errors++;
            $display("FAIL b2b_done_times got %p required '{105,209,313}", dq);
        end
        checks++;
        if (idle_cycles != 0) begin
            errors++;
            $display("FAIL b2b_no_idle got %0d idle cycles required 0", idle_cycles);
        end
        checks++;
        if (bus.FRAMECNT !== base + 16'd3) begin
            errors++;
            $display("FAIL b2b_framecnt got %h required %h", bus.FRAMECNT, base + 16'd3);
        end
        bus.CONT = 1'b0; bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        step();
    endtask

    task automatic test_gap();
        int dq[$];
        bus.CONT = 1'b1; bus.GAP = 8'd5; bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int c = 1; c <= 321; c++) begin
            if (bus.DONE) dq.push_back(c);
            if ((c >= 105 && c <= 109) || c == 214 || c == 215 || c == 320) begin
                checks++;
                if ({bus.SELDYN, bus.SELSTAT, bus.BUSY} !== 3'b001) begin
                    errors++;
                    $display("FAIL gap_idle cycle %0d got {dyn,stat,busy}=%b required 001", c, {bus.SELDYN, bus.SELSTAT, bus.BUSY});
                end
            end
            if (c == 110 || c == 216) begin
                checks++;
                if ({bus.SELDYN, bus.BITCNT} !== {1'b1, 7'd0}) begin
                    errors++;
                    $display("FAIL gap_resume cycle %0d got {dyn,bitcnt}=%b required 10000000", c, {bus.SELDYN, bus.BITCNT});
                end
            end
            if (c == 321) begin
                checks++;
                if ({bus.SELDYN, bus.SELSTAT, bus.BUSY} !== 3'b000) begin
                    errors++;
                    $display("FAIL gap_cont_drop got {dyn,stat,busy}=%b required 000", {bus.SELDYN, bus.SELSTAT, bus.BUSY});
                end
            end
            if (c == 150) bus.GAP = 8'd2;
            if (c == 320) bus.CONT = 1'b0;
            step();
        end
        checks++;
        if (dq.size() != 3 || dq[0] != 105 || dq[1] != 214 || dq[2] != 320) begin
            errors++;
            $display("FAIL gap_done_times got %p required '{105,214,320}", dq);
        end
        bus.GAP = '0;
    endtask

    task automatic test_abort();
        logic [15:0] base;
        base = m_frames;
        bus.CONT = 1'b0; bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int i = 0; i < 56; i++) step();
        checks++;
        if ({bus.SELSTAT, bus.BITCNT} !== {1'b1, 7'd40}) begin
            errors++;
            $display("FAIL abort_setup got {stat,bitcnt}=%b required 1 0101000", {bus.SELSTAT, bus.BITCNT});
        end
        bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        checks++;
        if ({bus.SELDYN, bus.SELSTAT, bus.BUSY, bus.DONE, bus.BITCNT, bus.FRAMECNT} !== {11'd0, base}) begin
            errors++;
            $display("FAIL abort_mid_stat got %h required %h",
                     {bus.SELDYN, bus.SELSTAT, bus.BUSY, bus.DONE, bus.BITCNT, bus.FRAMECNT}, {11'd0, base});
        end
        step();
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        checks++;
        if ({bus.SELDYN, bus.BITCNT} !== {1'b1, 7'd0}) begin
            errors++;
            $display("FAIL abort_restart got {dyn,bitcnt}=%b required 10000000", {bus.SELDYN, bus.BITCNT});
        end
        for (int i = 0; i < 103; i++) step();
        checks++;
        if ({bus.SELSTAT, bus.BITCNT} !== {1'b1, 7'd87}) begin
            errors++;
            $display("FAIL abort_last_setup got {stat,bitcnt}=%b required 11010111", {bus.SELSTAT, bus.BITCNT});
        end
        bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        checks++;
        if ({bus.DONE, bus.BUSY, bus.FRAMECNT} !== {2'b00, base}) begin
            errors++;
            $display("FAIL abort_last_stat got {done,busy,frames}=%h required %h", {bus.DONE, bus.BUSY, bus.FRAMECNT}, {2'b00, base});
        end
        bus.ABORT = 1'b1; bus.START = 1'b1;
        step();
        bus.ABORT = 1'b0; bus.START = 1'b0;
        checks++;
        if ({bus.BUSY, bus.SELDYN} !== 2'b00) begin
            errors++;
            $display("FAIL abort_with_start got {busy,dyn}=%b required 00", {bus.BUSY, bus.SELDYN});
        end
    endtask

    task automatic test_reset_mid();
        int ndyn, nstat, ndone;
        ndyn = 0; nstat = 0; ndone = 0;
        bus.CONT = 1'b0; bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int i = 0; i < 7; i++) step();
        checks++;
        if ({bus.SELDYN, bus.BITCNT} !== {1'b1, 7'd7}) begin
            errors++;
            $display("FAIL rst_setup got {dyn,bitcnt}=%b required 10000111", {bus.SELDYN, bus.BITCNT});
        end
        #2 RST_N = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bus.SELDYN, bus.SELSTAT, bus.BUSY, bus.DONE, bus.BITCNT, bus.FRAMECNT} !== '0) begin
            errors++;
            $display("FAIL rst_async got %h required 0", {bus.SELDYN, bus.SELSTAT, bus.BUSY, bus.DONE, bus.BITCNT, bus.FRAMECNT});
        end
        #3 RST_N = 1'b1;
        bus.START = 1'b1;
        step();
        for (int c = 1; c <= 105; c++) begin
            if (bus.SELDYN)  ndyn++;
            if (bus.SELSTAT) nstat++;
            if (bus.DONE)    ndone++;
            step();
        end
        bus.START = 1'b0;
        checks++;
        if (ndyn != NDYN || nstat != NSTAT || ndone != 1) begin
            errors++;
            $display("FAIL start_ignored got dyn=%0d stat=%0d done=%0d required %0d %0d 1", ndyn, nstat, ndone, NDYN, NSTAT);
        end
        bus.ABORT = 1'b1;
        step();
        bus.ABORT = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        force dut.framecnt_q = 16'hFFFF;
        m_frames = 16'hFFFF;
        @(negedge CLK);
        #1 release dut.framecnt_q;
        step();
        checks++;
        if (bus.FRAMECNT !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_preset got %h required ffff", bus.FRAMECNT);
        end
        bus.CONT = 1'b0; bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) step();
        checks++;
        if ({bus.DONE, bus.FRAMECNT} !== {1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL wrap got {done,frames}=%h required 10000", {bus.DONE, bus.FRAMECNT});
        end
        step();
    endtask

    task automatic test_random();
        int dut_done, mdl_done;
        dut_done = 0; mdl_done = 0;
        bus.CONT = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            bus.START = ($urandom_range(0, 7) == 0);
            bus.ABORT = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 199) == 0) bus.CONT = ~bus.CONT;
            if ($urandom_range(0, 99) == 0)  bus.GAP = GAPW'($urandom_range(0, 6));
            step();
            if (bus.DONE) dut_done++;
            if (m_done)   mdl_done++;
        end
        checks++;
        if (dut_done != mdl_done || bus.FRAMECNT !== m_frames) begin
            errors++;
            $display("FAIL random_totals got done=%0d frames=%h required done=%0d frames=%h",
                     dut_done, bus.FRAMECNT, mdl_done, m_frames);
        end
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.CONT = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_abort();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
